// File: rtl/ysyx_22040175_pipe_ctrl_pkg.sv
// Shared definitions for the ysyx_22040175 pipeline controller: register index width and
// controller state encoding.
package ysyx_22040175_pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ysyx_22040175_hazard_det.sv
// Load-use hazard detection: the ID instruction reads a register that the load in EX has not
// yet produced.
module ysyx_22040175_hazard_det
  import ysyx_22040175_pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic                      ex_is_load,
  output logic                      load_use
);

  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit  = id_rs1_used & (id_rs1_addr == ex_reg_waddr);
    rs2_hit  = id_rs2_used & (id_rs2_addr == ex_reg_waddr);
    // x0 is hard-wired, so a load targeting it never creates a dependency
    load_use = ex_is_load & ex_reg_wen & (ex_reg_waddr != '0) & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/ysyx_22040175_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use bubbles, redirect
// flushes, memory-wait freeze with timeout, and ebreak halt with a stall-cycle counter.
module ysyx_22040175_pipe_ctrl
  import ysyx_22040175_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr,
  input  logic                      ex_is_load,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  input  logic                      wb_ebreak,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_stall,
  output logic                      mem_wb_bubble,
  output logic                      halt,
  output logic                      mem_err,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e      state_q;
  logic             halt_q, mem_err_q;
  logic [WaitW-1:0] wait_q, wait_inc;
  logic [CNT_W-1:0] stall_q;
  logic             load_use, mem_wait, freeze;

  ysyx_22040175_hazard_det u_hazard_det (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_reg_wen  (ex_reg_wen),
    .ex_reg_waddr(ex_reg_waddr),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  always_comb begin
    mem_wait = mem_req & ~mem_ack;
    wait_inc = wait_q + WaitW'(1);
    // ebreak and memory waits both hold the whole pipe; HALT keeps it held forever
    freeze   = (state_q == StHalt) | mem_wait | ((state_q == StRun) & wb_ebreak);

    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      // the ID instruction is on the wrong path, so its load-use hazard is moot
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      halt_q    <= 1'b0;
      mem_err_q <= 1'b0;
      wait_q    <= '0;
      stall_q   <= '0;
    end else begin
      if (pc_stall && (state_q != StHalt) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      unique case (state_q)
        StRun: begin
          if (wb_ebreak) begin
            state_q <= StHalt;
            halt_q  <= 1'b1;
          end else if (mem_wait) begin
            state_q <= StMemWait;
            wait_q  <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (!mem_wait) begin
            state_q <= StRun;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_inc;
            if (wait_inc == WaitW'(MEM_TIMEOUT)) begin
              state_q   <= StHalt;
              halt_q    <= 1'b1;
              mem_err_q <= 1'b1;
            end
          end
        end
        StHalt: ;
        default: state_q <= StRun;
      endcase
    end
  end

  assign halt         = halt_q;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ysyx_22040175_pipe_ctrl.sv
// Scoreboard bench for the pipeline controller: each driven cycle queues its expected controls
// and registered state, which a negedge monitor pops and compares.
module tb_ysyx_22040175_pipe_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 6;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_RD   = 7'b0010100;
  localparam logic [6:0] C_FRZ  = 7'b1101011;
  localparam logic [6:0] C_RST  = 7'b0010101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_reg_waddr = '0;
  logic id_rs1_used = 0, id_rs2_used = 0, ex_reg_wen = 0, ex_is_load = 0;
  logic ex_redirect = 0, mem_req = 0, mem_ack = 0, wb_ebreak = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic mem_wb_bubble, halt, mem_err;
  logic [CntW-1:0] stall_cycles;
  logic [6:0] ctrl_obs;

  always #5 clk = ~clk;

  ysyx_22040175_pipe_ctrl #(.MEM_TIMEOUT(MemTimeout), .CNT_W(CntW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_reg_wen   (ex_reg_wen),
    .ex_reg_waddr (ex_reg_waddr),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .wb_ebreak    (wb_ebreak),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble),
    .halt         (halt),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles)
  );

  assign ctrl_obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                     ex_mem_stall, mem_wb_bubble};

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       u1, u2, wen;
    logic [4:0] waddr;
    logic       load, redir, req, ack, ebrk, rst;
  } in_t;

  typedef struct {
    string           name;
    logic [6:0]      ctrl;
    logic            h;
    logic            e;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [CntW-1:0] exp_cnt = '0;

  // Load into x5 in EX, `add x6,x5,x1` in ID.
  function automatic in_t lu_in();
    in_t i = '0;
    i.load = 1; i.wen = 1; i.waddr = 5'd5; i.rs1 = 5'd5; i.u1 = 1; i.rs2 = 5'd1; i.u2 = 1;
    return i;
  endfunction

  // Drive one cycle, queue what must be seen in it, and advance the count model.
  task automatic cyc(input string name, input in_t i, input logic [6:0] c, input logic h,
                     input logic e);
    rst = i.rst;
    id_rs1_addr = i.rs1; id_rs2_addr = i.rs2; id_rs1_used = i.u1; id_rs2_used = i.u2;
    ex_reg_wen = i.wen; ex_reg_waddr = i.waddr; ex_is_load = i.load;
    ex_redirect = i.redir; mem_req = i.req; mem_ack = i.ack; wb_ebreak = i.ebrk;
    sb.push_back('{name, c, h, e, exp_cnt});
    if (i.rst) exp_cnt = '0;
    else if (c[6] && !h && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      n_checks++;
      if ({ctrl_obs, halt, mem_err, stall_cycles} !== {x.ctrl, x.h, x.e, x.cnt}) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%b halt=%b err=%b cnt=%0d, want ctrl=%b halt=%b err=%b cnt=%0d",
                 x.name, ctrl_obs, halt, mem_err, stall_cycles, x.ctrl, x.h, x.e, x.cnt);
      end
    end
  end

  task automatic test_reset();
    in_t i = '0;
    i.rst = 1;
    cyc("reset_cycle", i, C_RST, 0, 0);
    n_checks++;
    if ({halt, mem_err, stall_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got halt=%b err=%b cnt=%0d, want 0 0 0",
               halt, mem_err, stall_cycles);
    end
    cyc("idle_after_reset", '0, C_NONE, 0, 0);
  endtask

  task automatic test_load_use();
    in_t i;
    cyc("lu_rs1", lu_in(), C_LU, 0, 0);
    cyc("lu_clean_next", '0, C_NONE, 0, 0);
    i = lu_in(); i.rs1 = 5'd7; i.rs2 = 5'd5;
    cyc("lu_rs2", i, C_LU, 0, 0);
    i = lu_in(); i.u1 = 0;
    cyc("lu_rs1_unused", i, C_NONE, 0, 0);
    i = lu_in(); i.wen = 0;
    cyc("lu_no_wen", i, C_NONE, 0, 0);
    i = lu_in(); i.load = 0;
    cyc("lu_not_load", i, C_NONE, 0, 0);
    i = lu_in(); i.waddr = 5'd0; i.rs1 = 5'd0;
    cyc("lu_x0", i, C_NONE, 0, 0);
    i = lu_in(); i.redir = 1;
    cyc("lu_with_redirect", i, C_RD, 0, 0);
    i = '0; i.redir = 1;
    cyc("redirect", i, C_RD, 0, 0);
  endtask

  task automatic test_mem_wait();
    in_t i = '0;
    i.req = 1;
    cyc("mw_freeze1", i, C_FRZ, 0, 0);
    cyc("mw_freeze2", i, C_FRZ, 0, 0);
    i.ack = 1;
    cyc("mw_release", i, C_NONE, 0, 0);
    cyc("mw_ack_first", i, C_NONE, 0, 0);
    i = lu_in(); i.redir = 1; i.req = 1;
    cyc("mw_over_redirect", i, C_FRZ, 0, 0);
    i = lu_in(); i.req = 1; i.ack = 1;
    cyc("mw_release_lu", i, C_LU, 0, 0);
    cyc("mw_idle", '0, C_NONE, 0, 0);
  endtask

  task automatic test_ebreak();
    in_t i = '0;
    i.ebrk = 1;
    cyc("ebreak", i, C_FRZ, 0, 0);
    i = lu_in(); i.redir = 1;
    for (int k = 0; k < 3; k++) cyc("halted_ebreak", i, C_FRZ, 1, 0);
    i = '0; i.rst = 1;
    cyc("reset_from_halt", i, C_RST, 1, 0);
    cyc("run_after_halt", '0, C_NONE, 0, 0);
  endtask

  task automatic test_timeout();
    in_t i = '0;
    i.req = 1;
    for (int k = 0; k < 4; k++) cyc("to_wait", i, C_FRZ, 0, 0);
    cyc("to_halted", i, C_FRZ, 1, 1);
    i.ack = 1; i.redir = 1;
    cyc("to_halt_holds", i, C_FRZ, 1, 1);
    n_checks++;
    if (halt !== 1'b1 || mem_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got halt=%b err=%b, want 1 1", halt, mem_err);
    end
    i = '0; i.rst = 1;
    cyc("to_reset", i, C_RST, 1, 1);
    cyc("to_after_reset", '0, C_NONE, 0, 0);
  endtask

  task automatic test_reset_in_wait();
    in_t i = '0;
    i.req = 1;
    cyc("rw_freeze1", i, C_FRZ, 0, 0);
    cyc("rw_freeze2", i, C_FRZ, 0, 0);
    i.rst = 1;
    cyc("rw_reset", i, C_RST, 0, 0);
    cyc("rw_after", '0, C_NONE, 0, 0);
    i.rst = 0;
    for (int k = 0; k < 3; k++) cyc("rw_wait_again", i, C_FRZ, 0, 0);
    i.ack = 1;
    cyc("rw_release", i, C_NONE, 0, 0);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 70; k++) cyc("sat_stall", lu_in(), C_LU, 0, 0);
    cyc("sat_hold", '0, C_NONE, 0, 0);
    cyc("sat_final", '0, C_NONE, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_ebreak();
    test_timeout();
    test_reset_in_wait();
    test_saturate();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
